// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
// Holds the state encoding and the width helper for the iteration counter.
package shift_add_mult_ctrl_pkg;

    // Encoding 2'd3 is unused and decodes back to ST_IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// N-bit unsigned ripple-carry adder, purely combinational.
// The carry-out is returned as s[N].
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   s
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < N; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        s[N] = carry[N];
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Iterative unsigned WIDTH x WIDTH multiplier (MULTU unit): one ripple-carry
// adder reused over WIDTH cycles, with a start/busy/done handshake.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               CNT_W    = clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] count;
    logic             last_iter;

    assign addend    = q[0] ? m : '0;
    assign last_iter = (count == LAST_CNT);

    ripple_carry_adder #(
        .N (WIDTH)
    ) u_adder (
        .a (acc),
        .b (addend),
        .s (sum)
    );

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: next_state = start ? ST_RUN : ST_IDLE;
            ST_RUN:  next_state = last_iter ? ST_DONE : ST_RUN;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // busy/done are registered from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            count   <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            done  <= (next_state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m       <= a;
                        q       <= b;
                        acc     <= '0;
                        count   <= '0;
                        product <= '0;
                    end
                end
                ST_RUN: begin
                    // Carry-out lands in the acc MSB, so nothing is lost on the shift.
                    acc   <= sum[WIDTH:1];
                    q     <= {sum[0], q[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (last_iter) begin
                        product <= {sum, q[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed self-checking bench for shift_add_mult_ctrl (WIDTH=8).
// Expected products are hand-computed constants.
module tb_shift_add_mult_ctrl;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int errors;
    int checks;

    shift_add_mult_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, check acceptance, latency, result and return to idle.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a,
                          input logic [WIDTH-1:0] op_b, input int exp_prod);
        int n;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_prod_cleared"}, 32'(product), 32'd0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_product"}, 32'(product), 32'(exp_prod));
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int n;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b1;
        a      = 8'd5;
        b      = 8'd5;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        run_op("mul_23x12", 8'd23, 8'd12, 276);
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37);
            b = 8'(i * 11);
            tick();
            check("hold_276", 32'(product), 32'd276);
        end

        run_op("mul_255x255", 8'd255, 8'd255, 65025);
        run_op("mul_0x71", 8'd0, 8'd71, 0);
        run_op("mul_35x0", 8'd35, 8'd0, 0);

        // Start held high through RUN with changing operands: no restart, no recapture.
        a     = 8'd8;
        b     = 8'd8;
        start = 1'b1;
        tick();
        a      = 8'd3;
        b      = 8'd3;
        pulses = 0;
        n      = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("hold_start_latency", 32'(n), 32'd8);
        check("hold_start_product", 32'(product), 32'd64);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check("hold_start_no_restart", 32'(pulses), 32'd0);
        check("hold_start_idle", 32'(busy), 32'd0);
        check("hold_start_product_kept", 32'(product), 32'd64);

        // Back-to-back: run_op ends in the first IDLE cycle after done.
        run_op("mul_13x11", 8'd13, 8'd11, 143);
        run_op("b2b_200x150", 8'd200, 8'd150, 30000);

        // Abort mid-RUN with reset in the 4th RUN cycle.
        a     = 8'd35;
        b     = 8'd71;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_product_stays", 32'(product), 32'd0);
        run_op("mul_1x1", 8'd1, 8'd1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Iterative unsigned multiplier controller that sequences one WIDTH-bit ripple-carry adder over WIDTH cycles using shift-and-add. It is the first multi-cycle arithmetic block for the fpga-mips ALU path, where it serves as the MULTU execution unit. It uses a start/busy/done handshake and holds the 2*WIDTH-bit product until the next accepted start.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; iteration count is WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand; captured on accepted start
b  input  WIDTH  multiplier; captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result; held until next accepted start

Behaviour:
- Reset (the edge where reset=1): state=IDLE, busy=0, done=0, product=0, internal acc/q/m/count=0. Reset overrides start and any in-flight operation.
- States and transitions:
  - IDLE: start=1 at edge E0 loads m<=a, q<=b, acc<=0, count<=0, product<=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: each edge computes sum[WIDTH:0] = acc + (q[0] ? m : 0) on the adder. It then shifts right: acc<=sum[WIDTH:1], q<={sum[0], q[WIDTH-1:1]}, count<=count+1. At the edge where count==WIDTH-1 (edge E0+WIDTH), it goes to DONE and product<={new acc, new q}.
  - DONE: done=1 for exactly this one cycle. Next edge goes to IDLE unconditionally.
- Latency: done high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after start is sampled. Throughput is one result per WIDTH+2 cycles.
- busy=1 from E0 until the DONE→IDLE edge. busy and done are registered outputs.
- start while busy=1 (RUN or DONE) is ignored: no restart, no queuing, and operands are not re-captured.
- a/b may change freely after E0 without affecting the result.
- product is stable from DONE until the next accepted start, which clears it to 0 at that edge.
- Arithmetic: unsigned only. The adder carry-out sum[WIDTH] is never lost because it shifts into acc MSB. The maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits, so there is no overflow.
- Zero operands take the full WIDTH iterations; there is no early termination, so latency is data-independent.
- count width is clog2(WIDTH)+1 bits so it cannot wrap before the compare.
- Reset mid-RUN aborts: done is never pulsed for the aborted operation and product reads 0.

Decomposition:
- Shared header mult_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2, with 2'd3 decoding to IDLE.
  - the clog2 helper used for count width.
- The existing RippleCarryAdder is instantiated with parameter N=WIDTH and purely combinational ports a, b, s[WIDTH:0].
- The controller FSM and shift registers stay in this module; no further sub-modules.

Test Plan:
- WIDTH=8, a=23, b=12, pulse start → busy next cycle, done pulse 9 cycles after start sample, product=276; product held at 276 for 5 idle cycles.
- a=255, b=255 → product=65025 (0xFE01); checks carry-out propagation on every iteration.
- a=0, b=71 and a=35, b=0 → product=0 each, done still exactly 9 cycles after start (no early exit).
- Start a=8,b=8. Hold start=1 and change a=3,b=3 during RUN → single done pulse, product=64, no restart.
- Next request issued in the first IDLE cycle after done → accepted, product cleared at that edge, correct result for the new operands.
- Start a=35, b=71, assert reset in the 4th RUN cycle → next cycle busy=0, done=0, product=0, state IDLE. Then a new start with 1×1 returns product=1.
